jam_cost_arbiter: RTL and testbench

- Shares the single combinational cost-table lookup port (W, J in; Cost out) between two permutation-evaluation engines, so the 40320-permutation search can be split across parallel engines.
- Arbitration is burst-locked and round-robin: one engine's lookup burst (normally 8 beats, one per worker) is granted contiguously, then priority passes to the other engine.
- Each accepted lookup returns its cost one cycle later on a registered response bus, with a per-requester valid.

---
 rtl/jam_cost_arbiter.sv | 157 +++++++++++++++
 tb/tb_jam_cost_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jam_cost_arbiter.sv
// Burst-locked round-robin arbiter that shares one combinational cost-table port
// between two permutation-evaluation engines, with a registered one-cycle response.
module jam_cost_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int COST_W    = 7
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req0_valid,
    input  logic [2:0]        req0_w,
    input  logic [2:0]        req0_j,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [2:0]        req1_w,
    input  logic [2:0]        req1_j,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [COST_W-1:0] rsp_cost,
    output logic              owner,
    output logic              busy,
    output logic              burst_err
);

    // state  | meaning
    // IDLE   | no grant; arbitrate next edge (one-cycle bubble)
    // GRANT0 | requester 0 owns the table port until release
    // GRANT1 | requester 1 owns the table port until release
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_owner;
    logic [COST_W-1:0]  r_rsp_cost;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic               r_burst_err;

    logic               w_gnt_valid;
    logic               w_gnt_last;
    logic               w_other_valid;
    logic               w_accept;
    logic               w_force;
    logic               w_release;

    assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

    always_comb begin
        w_gnt_valid   = 1'b0;
        w_gnt_last    = 1'b0;
        w_other_valid = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        W             = 3'd0;
        J             = 3'd0;
        case (r_state)
            GRANT0: begin
                req0_ready    = 1'b1;
                w_gnt_valid   = req0_valid;
                w_gnt_last    = req0_last;
                w_other_valid = req1_valid;
                if (req0_valid) begin
                    W = req0_w;
                    J = req0_j;
                end
            end
            GRANT1: begin
                req1_ready    = 1'b1;
                w_gnt_valid   = req1_valid;
                w_gnt_last    = req1_last;
                w_other_valid = req0_valid;
                if (req1_valid) begin
                    W = req1_w;
                    J = req1_j;
                end
            end
            default: ;
        endcase
    end

    assign w_accept  = w_gnt_valid;
    assign w_force   = w_accept && !w_gnt_last && (w_cnt_inc == LP_MAX);
    assign w_release = w_accept && (w_gnt_last || w_force);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid)
                    w_state_nxt = r_rr_ptr ? GRANT1 : GRANT0;
                else if (req0_valid)
                    w_state_nxt = GRANT0;
                else if (req1_valid)
                    w_state_nxt = GRANT1;
            end
            GRANT0: begin
                if (w_release)
                    w_state_nxt = w_other_valid ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (w_release)
                    w_state_nxt = w_other_valid ? GRANT0 : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_beat_cnt   <= '0;
            r_owner      <= 1'b0;
            r_rsp_cost   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_burst_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rsp0_valid <= w_accept && (r_state == GRANT0);
            r_rsp1_valid <= w_accept && (r_state == GRANT1);
            r_burst_err  <= w_force;
            if (w_accept)
                r_rsp_cost <= Cost;
            if (w_release) begin
                r_beat_cnt <= '0;
                r_rr_ptr   <= (r_state == GRANT0);
            end else if (w_accept) begin
                r_beat_cnt <= w_cnt_inc;
            end
            // owner tracks whoever holds the next grant; it is kept through IDLE
            if (w_state_nxt == GRANT0)
                r_owner <= 1'b0;
            else if (w_state_nxt == GRANT1)
                r_owner <= 1'b1;
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_cost   = r_rsp_cost;
    assign owner      = r_owner;
    assign busy       = (r_state == GRANT0) || (r_state == GRANT1);
    assign burst_err  = r_burst_err;

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Randomized bench for jam_cost_arbiter against a transaction-level reference model.
module tb_jam_cost_arbiter;

    localparam int MAX_BURST = 8;
    localparam int COST_W    = 7;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              req0_valid = 1'b0, req0_last = 1'b0;
    logic [2:0]        req0_w = '0, req0_j = '0;
    logic              req1_valid = 1'b0, req1_last = 1'b0;
    logic [2:0]        req1_w = '0, req1_j = '0;
    logic              req0_ready, req1_ready;
    logic [2:0]        W, J;
    logic [COST_W-1:0] Cost;
    logic              rsp0_valid, rsp1_valid;
    logic [COST_W-1:0] rsp_cost;
    logic              owner, busy, burst_err;

    int checks = 0;
    int failures = 0;

    // reference model state: holder is -1 when nobody owns the port
    int m_holder, m_rr, m_cnt, m_owner, m_cost, m_err;
    int m_rsp [2];
    int n_err_seen;

    jam_cost_arbiter #(.MAX_BURST(MAX_BURST), .COST_W(COST_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(req0_valid), .req0_w(req0_w), .req0_j(req0_j),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_w(req1_w), .req1_j(req1_j),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .W(W), .J(J), .Cost(Cost),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_cost(rsp_cost),
        .owner(owner), .busy(busy), .burst_err(burst_err)
    );

    always #5 CLK = ~CLK;

    function automatic int cost_of(input int w, input int j);
        return w * 10 + j;
    endfunction

    assign Cost = COST_W'(cost_of(int'(W), int'(J)));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1; m_rr = 0; m_cnt = 0; m_owner = 0;
        m_cost = 0; m_err = 0; m_rsp[0] = 0; m_rsp[1] = 0;
    endtask

    task automatic model_step();
        int v [2], l [2], w [2], j [2];
        int h;
        v[0] = int'(req0_valid); v[1] = int'(req1_valid);
        l[0] = int'(req0_last);  l[1] = int'(req1_last);
        w[0] = int'(req0_w); w[1] = int'(req1_w);
        j[0] = int'(req0_j); j[1] = int'(req1_j);
        m_rsp[0] = 0; m_rsp[1] = 0; m_err = 0;
        if (m_holder < 0) begin
            if (v[0] && v[1]) m_holder = m_rr;
            else if (v[0])    m_holder = 0;
            else if (v[1])    m_holder = 1;
            if (m_holder >= 0) m_owner = m_holder;
        end else if (v[m_holder]) begin
            h = m_holder;
            m_rsp[h] = 1;
            m_cost = cost_of(w[h], j[h]);
            m_cnt++;
            if (l[h] || m_cnt == MAX_BURST) begin
                m_err = (!l[h]) ? 1 : 0;
                m_cnt = 0;
                m_rr = 1 - h;
                if (v[1-h]) begin
                    m_holder = 1 - h;
                    m_owner = 1 - h;
                end else begin
                    m_holder = -1;
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("rsp0_valid", int'(rsp0_valid), m_rsp[0]);
        chk("rsp1_valid", int'(rsp1_valid), m_rsp[1]);
        if (m_rsp[0] || m_rsp[1]) chk("rsp_cost", int'(rsp_cost), m_cost);
        chk("owner", int'(owner), m_owner);
        chk("busy", int'(busy), (m_holder >= 0) ? 1 : 0);
        chk("burst_err", int'(burst_err), m_err);
        if (burst_err) n_err_seen++;
    endtask

    task automatic check_comb();
        int ew, ej;
        ew = 0; ej = 0;
        if (m_holder == 0 && req0_valid) begin ew = int'(req0_w); ej = int'(req0_j); end
        if (m_holder == 1 && req1_valid) begin ew = int'(req1_w); ej = int'(req1_j); end
        chk("req0_ready", int'(req0_ready), (m_holder == 0) ? 1 : 0);
        chk("req1_ready", int'(req1_ready), (m_holder == 1) ? 1 : 0);
        chk("W", int'(W), ew);
        chk("J", int'(J), ej);
    endtask

    task automatic drive_random(input int vpct, input int last_den);
        req0_valid = ($urandom_range(0, 99) < vpct);
        req1_valid = ($urandom_range(0, 99) < vpct);
        req0_w = 3'($urandom_range(0, 7)); req0_j = 3'($urandom_range(0, 7));
        req1_w = 3'($urandom_range(0, 7)); req1_j = 3'($urandom_range(0, 7));
        req0_last = ($urandom_range(0, last_den - 1) == 0);
        req1_last = ($urandom_range(0, last_den - 1) == 0);
    endtask

    task automatic run_cycles(input int n, input int vpct, input int last_den);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
            model_step();
            #1;
            check_regs();
            drive_random(vpct, last_den);
            #1;
            check_comb();
        end
    endtask

    initial begin
        model_reset();
        n_err_seen = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_cost", int'(rsp_cost), 0);
        chk("rst_W", int'(W), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_cycles(5, 0, 1);                 // idle: no requests
        run_cycles(3000, 80, 4);             // mostly terminated bursts
        run_cycles(3000, 90, 20);            // long bursts: forced releases
        // both requesters hammering and never signalling last
        run_cycles(400, 100, 1000);

        // asynchronous reset between edges, mid-grant
        run_cycles(3, 100, 1000);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        @(negedge CLK);
        RST_N = 1'b1;
        run_cycles(2000, 75, 6);

        chk("burst_err_seen", (n_err_seen > 0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
